mem_loader: RTL and testbench

- Writer side of the instruction-memory byte-load port: drives mem_loader_write_addr / mem_loader_write_data / mem_loader_write_en.
- Consumes a byte stream from a UART receiver (valid/ready), parses a framed program image and writes it byte-by-byte into instruction memory.
- Holds the CPU in reset while loading and reports done or error.

---
 rtl/mem_loader.sv | 171 +++++++++++++++++
 tb/tb_mem_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Instruction-memory loader: parses a framed image (sync, LEN, payload, checksum) from a
// byte stream and writes it byte-by-byte into instruction memory, holding the CPU in reset.
module mem_loader #(
    parameter int unsigned MEMORY_SIZE    = 8196,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] mem_loader_write_addr,
    output logic [7:0]  mem_loader_write_data,
    output logic        mem_loader_write_en,
    output logic        cpu_reset,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [31:0] MaxLen     = 32'(MEMORY_SIZE - BASE_ADDR);
    localparam logic [31:0] TimeoutLim = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] BaseAddr   = 32'(BASE_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e      state_q;
    logic [31:0] len_q;
    logic [1:0]  len_cnt_q;
    logic [31:0] byte_cnt_q;
    logic [31:0] idle_cnt_q;
    logic [7:0]  csum_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [7:0]  data_q;
    logic        cpu_reset_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        xfer;
    logic        in_frame;
    logic        timeout;
    logic [31:0] len_next;

    always_comb begin
        rx_ready = 1'b0;
        if (!rst) begin
            rx_ready = (state_q != StDone) && (state_q != StErr);
        end
    end

    assign xfer     = rx_valid && rx_ready;
    assign in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign timeout  = (idle_cnt_q + 32'd1) >= TimeoutLim;
    // LEN arrives little-endian, so shift each new byte in from the top.
    assign len_next = {rx_data, len_q[31:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            len_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            csum_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Inter-byte watchdog; a transfer in the limit cycle wins over the abort.
            if (in_frame) begin
                if (xfer) begin
                    idle_cnt_q <= '0;
                end else if (timeout) begin
                    state_q <= StErr;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + 32'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    idle_cnt_q <= '0;
                    if (xfer && rx_data == SYNC_BYTE) begin
                        state_q     <= StLen;
                        busy_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        len_q       <= '0;
                        len_cnt_q   <= '0;
                        byte_cnt_q  <= '0;
                        csum_q      <= '0;
                    end
                end
                StLen: begin
                    if (xfer) begin
                        len_q     <= len_next;
                        len_cnt_q <= len_cnt_q + 2'd1;
                        if (len_cnt_q == 2'd3) begin
                            if (len_next > MaxLen) begin
                                state_q <= StErr;
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end else if (len_next == 32'd0) begin
                                state_q <= StCsum;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        we_q       <= 1'b1;
                        addr_q     <= BaseAddr + byte_cnt_q;
                        data_q     <= rx_data;
                        csum_q     <= csum_q + rx_data;
                        byte_cnt_q <= byte_cnt_q + 32'd1;
                        if (byte_cnt_q + 32'd1 == len_q) begin
                            state_q <= StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (xfer) begin
                        busy_q <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q     <= StDone;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                StErr:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_loader_write_en   = we_q;
    assign mem_loader_write_addr = addr_q;
    assign mem_loader_write_data = data_q;
    assign cpu_reset             = cpu_reset_q;
    assign busy                  = busy_q;
    assign load_done             = done_q;
    assign load_error            = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: expected writes are queued as bytes are driven and
// compared against writes captured from the memory port.
module tb_mem_loader;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        cpu_reset;
    logic        busy;
    logic        load_done;
    logic        load_error;

    mem_loader #(
        .MEMORY_SIZE   (8196),
        .BASE_ADDR     (0),
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .rx_ready             (rx_ready),
        .mem_loader_write_addr(wr_addr),
        .mem_loader_write_data(wr_data),
        .mem_loader_write_en  (wr_en),
        .cpu_reset            (cpu_reset),
        .busy                 (busy),
        .load_done            (load_done),
        .load_error           (load_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = '0;
    logic [31:0] last_acc;

    logic [7:0] prog1 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] prog2 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) obs_q.push_back(wr_t'{wr_addr, wr_data, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chk1(input string tag, input logic o, input logic e);
        chk(tag, {31'd0, o}, {31'd0, e});
    endtask

    // Drive one byte starting at a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit pay, input logic [31:0] a);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("rx_ready_wait", rx_ready, 1'b1);
        if (pay) exp_q.push_back(wr_t'{a, b, cyc + 32'd1});
        @(negedge clk);
        rx_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic send_hdr(input logic [31:0] len);
        send_byte(8'hA5, 1'b0, 32'd0);
        chk1("busy_after_sync", busy, 1'b1);
        chk1("cpu_reset_after_sync", cpu_reset, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b0, 32'd0);
    endtask

    task automatic check_writes(input string tag);
        wr_t e;
        wr_t o;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_addr"}, o.addr, e.addr);
            chk({tag, "_data"}, {24'd0, o.data}, {24'd0, e.data});
            chk({tag, "_lat"}, o.cyc, e.cyc);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2;
        chk1("rst_rx_ready", rx_ready, 1'b0);
        chk1("rst_cpu_reset", cpu_reset, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_we", wr_en, 1'b0);
        chk("rst_addr", wr_addr, 32'd0);
        chk1("rst_done", load_done, 1'b0);
        chk1("rst_err", load_error, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("idle_rx_ready", rx_ready, 1'b1);

        // Good 8-byte load
        send_hdr(32'd8);
        for (int i = 0; i < 8; i++) send_byte(prog1[i], 1'b1, 32'(i));
        send_byte(8'hB6, 1'b0, 32'd0);
        chk1("ok_done", load_done, 1'b1);
        chk1("ok_cpu_reset", cpu_reset, 1'b0);
        chk1("ok_busy", busy, 1'b0);
        chk1("ok_rx_ready_done", rx_ready, 1'b0);
        @(negedge clk);
        chk1("ok_done_pulse", load_done, 1'b0);
        chk1("ok_rx_ready_idle", rx_ready, 1'b1);
        check_writes("ok_wr");

        // Bad checksum
        send_hdr(32'd8);
        for (int i = 0; i < 8; i++) send_byte(prog1[i], 1'b1, 32'(i));
        send_byte(8'hB7, 1'b0, 32'd0);
        chk1("csum_err", load_error, 1'b1);
        chk1("csum_cpu_reset", cpu_reset, 1'b1);
        chk1("csum_busy", busy, 1'b0);
        @(negedge clk);
        chk1("csum_err_pulse", load_error, 1'b0);
        check_writes("csum_wr");

        // Idle noise then an empty frame
        send_byte(8'h00, 1'b0, 32'd0);
        chk1("noise0_busy", busy, 1'b0);
        send_byte(8'hFF, 1'b0, 32'd0);
        chk1("noise1_busy", busy, 1'b0);
        send_byte(8'h5A, 1'b0, 32'd0);
        chk1("noise2_busy", busy, 1'b0);
        send_hdr(32'd0);
        send_byte(8'h00, 1'b0, 32'd0);
        chk1("empty_done", load_done, 1'b1);
        chk1("empty_cpu_reset", cpu_reset, 1'b0);
        @(negedge clk);
        check_writes("empty_wr");

        // Oversized length
        send_hdr(32'h0000_2005);
        chk1("len_err", load_error, 1'b1);
        chk1("len_busy", busy, 1'b0);
        @(negedge clk);
        check_writes("len_wr");

        // Stall after three payload bytes
        send_hdr(32'd8);
        for (int i = 0; i < 3; i++) send_byte(prog1[i], 1'b1, 32'(i));
        n = 0;
        while (load_error !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_lat", cyc - last_acc, 32'(TO));
        @(negedge clk);
        chk1("timeout_rx_ready", rx_ready, 1'b1);
        chk1("timeout_cpu_reset", cpu_reset, 1'b1);
        check_writes("timeout_wr");

        // Reset mid-frame, then a fresh load
        send_hdr(32'd4);
        for (int i = 0; i < 2; i++) send_byte(prog2[i], 1'b1, 32'(i));
        @(negedge clk);
        check_writes("abort_wr");
        rst = 1'b1;
        #1;
        chk1("abort_rx_ready", rx_ready, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_cpu_reset", cpu_reset, 1'b1);
        chk1("abort_we", wr_en, 1'b0);
        chk("abort_addr", wr_addr, 32'd0);
        chk1("abort_err", load_error, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_hdr(32'd4);
        for (int i = 0; i < 4; i++) send_byte(prog2[i], 1'b1, 32'(i));
        send_byte(8'h38, 1'b0, 32'd0);
        chk1("reload_done", load_done, 1'b1);
        chk1("reload_cpu_reset", cpu_reset, 1'b0);
        @(negedge clk);
        check_writes("reload_wr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
